a2d_scan_controller: RTL and testbench
======================================

Name: a2d_scan_controller

Overview:
- Parametrised successor to the single-channel ALE/START/EOC A/D handshake controller.
- Scans up to NUM_CH multiplexed analog channels round-robin, skipping channels masked off.
- Drives the ADC's address, ALE, START and OE strobes, and captures conversion data.
- Emits one tagged sample per conversion toward downstream logic (display or accumulator).

Parameters:
NUM_CH, 8, number of analog mux channels (2..16)
ADDR_W, 3, channel address width; must satisfy 2**ADDR_W >= NUM_CH
DATA_W, 8, ADC data bus width
START_CYC, 1, START pulse width in clk cycles (>=1)
OE_CYC, 2, OE assertion length in cycles; data captured on the last OE cycle (>=1)
TIMEOUT_CYC, 1024, max cycles from START entry to EOC rising before abort (used only with A2D_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run scan while high
ch_mask  in  NUM_CH  1 = channel included in scan
eoc  in  1  ADC end-of-conversion, asynchronous to clk
adc_data  in  DATA_W  ADC output bus, valid while oe high
addr  out  ADDR_W  mux channel address
ale  out  1  address latch enable
start  out  1  start conversion
oe  out  1  ADC output enable
busy  out  1  high in every state except IDLE
sample_valid  out  1  one-cycle pulse, sample_data/sample_ch valid
sample_data  out  DATA_W  captured conversion result
sample_ch  out  ADDR_W  channel of sample_data
timeout_err  out  1  one-cycle pulse on conversion abort

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, channel pointer 0, all outputs 0, synchroniser flops 0.
- eoc passes through a 2-flop synchroniser (eoc_s). All EOC decisions use eoc_s, which adds 2 cycles of latency.
- Channel select (combinational from pointer p and ch_mask):
  - Choose the lowest enabled index i >= p.
  - If none exists, wrap to the lowest enabled index overall.
- States and transitions:
  - IDLE: if enable && |ch_mask, register addr <= selected channel, then go to ALE. Otherwise stay in IDLE.
  - ALE: ale=1 for 1 cycle, then go to START.
  - START: start=1 for START_CYC cycles, then go to WAIT_LO.
  - WAIT_LO: go to WAIT_HI when eoc_s==0.
  - WAIT_HI: go to READ when eoc_s==1.
  - READ: oe=1 for OE_CYC cycles. On the last cycle, register sample_data <= adc_data and sample_ch <= addr. Then go to DONE.
  - DONE: sample_valid=1 for 1 cycle. Pointer <= (addr+1) mod NUM_CH. Then go to IDLE.
- addr is held stable from ALE through DONE. ale, start and oe are mutually exclusive.
- Minimum per-sample period: 1 + 1 + START_CYC + (WAIT_LO ≥ 1) + (WAIT_HI ≥ 1) + OE_CYC + 1 cycles.
- Deasserting enable mid-conversion does not abort; the current sample completes, then the block parks in IDLE.
- A ch_mask change mid-conversion affects only the next selection.
- All-zero mask while enabled: the block stays in IDLE and busy=0.
- Single enabled channel: that channel is re-converted back to back.
- Pointer wrap: when addr == NUM_CH-1, the next pointer is 0.
- Reset asserted mid-operation: all strobes drop immediately (asynchronous) and no sample_valid is emitted.

Optional Feature:
- Macro A2D_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on START entry and increments in START, WAIT_LO and WAIT_HI.
  - If it reaches TIMEOUT_CYC-1 while still in START, WAIT_LO or WAIT_HI, then: timeout_err=1 for 1 cycle, no sample_valid, pointer advances past the current channel, and the state goes to IDLE.
- Undefined: the counter is not built, timeout_err is tied 0, and WAIT states wait indefinitely.

Decomposition:
- Shared package a2d_pkg holds:
  - the state enum (IDLE, ALE, START, WAIT_LO, WAIT_HI, READ, DONE);
  - the state width constant;
  - the default DATA_W/ADDR_W constants.
- One sub-module: a2d_sync, a 2-flop single-bit synchroniser with asynchronous active-low reset, used for eoc.

Test Plan:
- NUM_CH=8, mask=8'hFF, enable=1, ADC model (eoc falls 2 cycles after start, rises 20 cycles later, data=0x40+ch) -> sample_ch sequence 0,1,...,7,0; sample_data 0x40..0x47.
- mask=8'b1010_0100, pointer 0 -> order 2,5,7,2. addr never takes 0,1,3,4,6.
- enable dropped during WAIT_HI of ch 3 -> ch 3 sample_valid still pulses, then busy=0 and ale stays 0.
- mask=0 with enable=1 for 100 cycles -> busy=0 and no strobes.
- A2D_TIMEOUT_EN, TIMEOUT_CYC=64, eoc held high on ch 1 -> timeout_err after 64 cycles, no sample_valid, next ALE with addr=2.
- rst_n pulsed low during READ -> oe, sample_valid and busy are 0 in the same cycle. After release, the scan restarts at ch 0.

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared definitions for the multi-channel A/D scan controller:
// FSM state encoding and default bus widths.
package a2d_pkg;

    localparam int STATE_W    = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ALE     = 3'd1,
        START   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        READ    = 3'd5,
        DONE    = 3'd6
    } a2d_state_t;

endpackage

// File: rtl/a2d_sync.sv
// Two-flop single-bit synchroniser for signals arriving from outside clk.
module a2d_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/a2d_scan_controller.sv
// Round-robin multi-channel ALE/START/EOC/OE A/D scan controller.
// Optional build macro: A2D_TIMEOUT_EN adds a conversion-abort watchdog
// (TIMEOUT_CYC); without it timeout_err is tied low and waits are unbounded.
module a2d_scan_controller
    import a2d_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int START_CYC   = 1,
    parameter int OE_CYC      = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic [ADDR_W-1:0] addr,
    output logic              ale,
    output logic              start,
    output logic              oe,
    output logic              busy,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] sample_ch,
    output logic              timeout_err
);

    localparam int PH_MAX = (START_CYC > OE_CYC) ? START_CYC : OE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    // Reject configurations the address bus or watchdog cannot represent.
    if (NUM_CH < 2 || NUM_CH > 16 || (1 << ADDR_W) < NUM_CH ||
        START_CYC < 1 || OE_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("a2d_scan_controller: illegal parameter set");
    end

    logic                eoc_s;
    a2d_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [PH_W-1:0]     ph_cnt_reg, ph_cnt_next;
    logic [DATA_W-1:0]   sample_data_reg, sample_data_next;
    logic [ADDR_W-1:0]   sample_ch_reg, sample_ch_next;
    logic [NUM_CH-1:0]   upper_mask;
    logic [ADDR_W-1:0]   sel_ch;
    logic [ADDR_W-1:0]   ptr_after;
    logic                timeout_hit;

    a2d_sync u_eoc_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (eoc),
        .q     (eoc_s)
    );

    // Channels at or above the pointer that are still enabled.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_upper
        assign upper_mask[gi] = ch_mask[gi] && (32'(gi) >= 32'(ptr_reg));
    end

    // Lowest enabled channel >= pointer, else wrap to lowest enabled overall.
    always_comb begin
        sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) sel_ch = ADDR_W'(i);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (upper_mask[i]) sel_ch = ADDR_W'(i);
        end
    end

    assign ptr_after = (addr_reg == ADDR_W'(NUM_CH - 1)) ? '0 : addr_reg + 1'b1;

`ifdef A2D_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             in_conv;

    assign in_conv = (state_reg == START) || (state_reg == WAIT_LO) ||
                     (state_reg == WAIT_HI);

    // Watchdog: cleared as START is entered, counts while awaiting EOC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ALE) begin
            tmo_cnt_reg <= '0;
        end else if (in_conv) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = in_conv && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            addr_reg        <= '0;
            ph_cnt_reg      <= '0;
            sample_data_reg <= '0;
            sample_ch_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            addr_reg        <= addr_next;
            ph_cnt_reg      <= ph_cnt_next;
            sample_data_reg <= sample_data_next;
            sample_ch_reg   <= sample_ch_next;
        end
    end

    // Next-state logic and strobe decode; strobes come straight from state
    // so an asynchronous reset drops them without waiting for a clock.
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        addr_next        = addr_reg;
        ph_cnt_next      = ph_cnt_reg;
        sample_data_next = sample_data_reg;
        sample_ch_next   = sample_ch_reg;
        ale              = 1'b0;
        start            = 1'b0;
        oe               = 1'b0;
        sample_valid     = 1'b0;
        busy             = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (enable && |ch_mask) begin
                    addr_next  = sel_ch;
                    state_next = ALE;
                end
            end
            ALE: begin
                ale         = 1'b1;
                ph_cnt_next = '0;
                state_next  = START;
            end
            START: begin
                start = 1'b1;
                if (ph_cnt_reg == PH_W'(START_CYC - 1)) begin
                    state_next = WAIT_LO;
                end else begin
                    ph_cnt_next = ph_cnt_reg + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!eoc_s) state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (eoc_s) begin
                    ph_cnt_next = '0;
                    state_next  = READ;
                end
            end
            READ: begin
                oe = 1'b1;
                if (ph_cnt_reg == PH_W'(OE_CYC - 1)) begin
                    sample_data_next = adc_data;
                    sample_ch_next   = addr_reg;
                    state_next       = DONE;
                end else begin
                    ph_cnt_next = ph_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                sample_valid = 1'b1;
                ptr_next     = ptr_after;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A stalled conversion is abandoned and the scan moves on.
        if (timeout_hit) begin
            ptr_next   = ptr_after;
            state_next = IDLE;
        end
    end

    assign addr        = addr_reg;
    assign sample_data = sample_data_reg;
    assign sample_ch   = sample_ch_reg;
    assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_a2d_scan_controller.sv
// Directed bench for a2d_scan_controller with a behavioural ADC model.
module tb_a2d_scan_controller;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '1;
    logic              eoc;
    logic [DATA_W-1:0] adc_data;
    logic [ADDR_W-1:0] addr;
    logic              ale, start, oe, busy, sample_valid, timeout_err;
    logic [DATA_W-1:0] sample_data;
    logic [ADDR_W-1:0] sample_ch;

    int vectors = 0;
    int miscompares = 0;

    a2d_scan_controller #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .START_CYC(1), .OE_CYC(2), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
        .eoc(eoc), .adc_data(adc_data), .addr(addr), .ale(ale),
        .start(start), .oe(oe), .busy(busy), .sample_valid(sample_valid),
        .sample_data(sample_data), .sample_ch(sample_ch),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // ADC model: eoc falls 2 cycles after START, rises 20 cycles later.
    int   adc_cnt;
    logic stuck_ch1 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          adc_cnt <= -1;
        else if (start)                      adc_cnt <= 0;
        else if (adc_cnt >= 0 && adc_cnt < 100) adc_cnt <= adc_cnt + 1;
    end

    assign eoc      = (stuck_ch1 && addr == 3'd1) ? 1'b1 :
                      !(adc_cnt >= 2 && adc_cnt < 22);
    assign adc_data = oe ? (8'h40 + 8'(addr)) : 8'h00;

    // Background monitors for invariants.
    int   excl_err = 0;
    int   forbid_err = 0;
    int   tmo_seen = 0;
    logic forbid_watch = 1'b0;

    always @(negedge clk) begin
        if (32'(ale) + 32'(start) + 32'(oe) > 1) excl_err++;
        if (forbid_watch && busy && !(addr == 3'd2 || addr == 3'd5 || addr == 3'd7))
            forbid_err++;
        if (timeout_err) tmo_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the next sample_valid pulse and return its payload.
    task automatic next_sample(input string tag, output logic [ADDR_W-1:0] ch,
                               output logic [DATA_W-1:0] data);
        int   n = 0;
        logic found = 1'b0;
        ch = '0;
        data = '0;
        while (!found && n < 500) begin
            @(negedge clk);
            n++;
            if (sample_valid) begin
                found = 1'b1;
                ch    = sample_ch;
                data  = sample_data;
            end
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        $display("sample %s ch=%0d data=%02h", tag, ch, data);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [ADDR_W-1:0] ch;
    logic [DATA_W-1:0] data;
    int                n, act;
    logic              seen;
    logic [ADDR_W-1:0] exp_ord[4] = '{3'd2, 3'd5, 3'd7, 3'd2};

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ale", 32'(ale), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_oe", 32'(oe), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_sdata", 32'(sample_data), 0);
        rst_n = 1'b1;

        // Full mask: 0..7 then wrap to 0
        ch_mask = 8'hFF;
        enable  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            next_sample("full", ch, data);
            chk("full_ch", 32'(ch), 32'(i % 8));
            chk("full_data", 32'(data), 32'h40 + 32'(i % 8));
        end

        // Asynchronous reset during READ
        n = 0;
        while (!oe && n < 500) begin @(negedge clk); n++; end
        chk("oe_reached", 32'(oe), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstrd_oe", 32'(oe), 0);
        chk("rstrd_busy", 32'(busy), 0);
        chk("rstrd_valid", 32'(sample_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_sample("restart", ch, data);
        chk("restart_ch", 32'(ch), 0);
        enable = 1'b0;
        @(negedge clk);
        chk("park_busy", 32'(busy), 0);

        // Sparse mask from pointer 0
        pulse_reset();
        ch_mask      = 8'b1010_0100;
        forbid_watch = 1'b1;
        enable       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_sample("sparse", ch, data);
            chk("sparse_ch", 32'(ch), 32'(exp_ord[i]));
        end
        enable       = 1'b0;
        forbid_watch = 1'b0;
        @(negedge clk);
        chk("sparse_forbid", 32'(forbid_err), 0);

        // Single channel back to back, then enable drop in WAIT_HI
        ch_mask = 8'b0000_1000;
        enable  = 1'b1;
        next_sample("single0", ch, data);
        chk("single0_ch", 32'(ch), 3);
        next_sample("single1", ch, data);
        chk("single1_ch", 32'(ch), 3);
        n = 0;
        while (eoc && n < 200) begin @(negedge clk); n++; end
        chk("eoc_fell", 32'(eoc), 0);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        next_sample("drop", ch, data);
        chk("drop_ch", 32'(ch), 3);
        chk("drop_data", 32'(data), 32'h43);
        act = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy || ale) act++;
        end
        chk("drop_parked", 32'(act), 0);

        // Empty mask while enabled
        ch_mask = '0;
        enable  = 1'b1;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || ale || start || oe || sample_valid) act++;
        end
        chk("nomask_idle", 32'(act), 0);
        enable = 1'b0;

`ifdef A2D_TIMEOUT_EN
        // Stuck EOC on channel 1 triggers abort, scan resumes at channel 2
        pulse_reset();
        ch_mask   = 8'b0000_0110;
        stuck_ch1 = 1'b1;
        enable    = 1'b1;
        n = 0;
        while (!start && n < 50) begin @(negedge clk); n++; end
        chk("tmo_start_addr", 32'(addr), 1);
        n = 0;
        seen = 1'b0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            n++;
            if (sample_valid) seen = 1'b1;
        end
        chk("tmo_cycles", 32'(n), 63);
        chk("tmo_novalid", 32'(seen), 0);
        n = 0;
        while (!ale && n < 50) begin @(negedge clk); n++; end
        chk("tmo_next_ale", 32'(ale), 1);
        chk("tmo_next_addr", 32'(addr), 2);
        enable    = 1'b0;
        stuck_ch1 = 1'b0;
        repeat (40) @(negedge clk);
        chk("tmo_count", 32'(tmo_seen), 1);
`else
        chk("tmo_count", 32'(tmo_seen), 0);
`endif
        chk("strobe_excl", 32'(excl_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
